// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO
// Optional signed accumulate (MADD/MSUB) is built only when MULDIV_MADD_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand, rem, quot, divisor, dividend;
  logic               isDiv, negRes, negRem;
`ifdef MULDIV_MADD_EN
  logic               accEn, accSub;
`endif

  logic               isMul, isDivOp, isSigned;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     mulSum, divShift, divDiff;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotFinal, remFinal;

  always_comb begin
    isMul    = (Op == 3'b000) || (Op == 3'b001);
    isDivOp  = (Op == 3'b010) || (Op == 3'b011);
    isSigned = (Op == 3'b000) || (Op == 3'b010);
`ifdef MULDIV_MADD_EN
    if (Op[2:1] == 2'b11) begin
      isMul    = 1'b1;
      isSigned = 1'b1;
    end
`endif
    absA = (isSigned && OperandA[WIDTH-1]) ? -OperandA : OperandA;
    absB = (isSigned && OperandB[WIDTH-1]) ? -OperandB : OperandB;
    // Shift-add: upper half accumulates, multiplier drains out of the low half
    mulSum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    // Restoring divide: a borrow out of the top bit means the trial subtract failed
    divShift = {rem, quot[WIDTH-1]};
    divDiff  = divShift - {1'b0, divisor};
    product   = negRes ? -prod : prod;
    quotFinal = negRes ? -quot : quot;
    remFinal  = negRem ? -rem : rem;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      prod     <= '0;
      mcand    <= '0;
      rem      <= '0;
      quot     <= '0;
      divisor  <= '0;
      dividend <= '0;
      isDiv    <= 1'b0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
`ifdef MULDIV_MADD_EN
      accEn    <= 1'b0;
      accSub   <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            negRes   <= isSigned && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
            negRem   <= isSigned && OperandA[WIDTH-1];
            dividend <= OperandA;
            cnt      <= '0;
`ifdef MULDIV_MADD_EN
            accEn    <= (Op[2:1] == 2'b11);
            accSub   <= Op[0];
`endif
            if (isMul) begin
              prod  <= {{WIDTH{1'b0}}, absB};
              mcand <= absA;
              isDiv <= 1'b0;
              Busy  <= 1'b1;
              state <= MUL;
            end else if (isDivOp) begin
              rem     <= '0;
              quot    <= absA;
              divisor <= absB;
              isDiv   <= 1'b1;
              Busy    <= 1'b1;
              state   <= DIV;
            end else if (Op == 3'b100) begin
              HI <= OperandA;
            end else if (Op == 3'b101) begin
              LO <= OperandA;
            end
          end
        end
        MUL: begin
          prod <= {mulSum, prod[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= FIN;
        end
        DIV: begin
          rem  <= divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
          quot <= {quot[WIDTH-2:0], ~divDiff[WIDTH]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= FIN;
        end
        FIN: begin
          if (isDiv) begin
            if (divisor == '0) begin
              HI <= dividend;
              LO <= '1;
            end else begin
              HI <= remFinal;
              LO <= quotFinal;
            end
          end
`ifdef MULDIV_MADD_EN
          else if (accEn) begin
            {HI, LO} <= accSub ? ({HI, LO} - product) : ({HI, LO} + product);
          end
`endif
          else begin
            {HI, LO} <= product;
          end
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic        CLK = 1'b0;
  logic        Reset, Start;
  logic [2:0]  Op;
  logic [31:0] OperandA, OperandB;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] expQ[$];
  logic [63:0] mHL;

  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    model = hl;
    case (op)
      3'd0: model = sa * sb;
      3'd1: model = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) model = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          model = {r[31:0], q[31:0]};
        end
      end
      3'd3: model = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      3'd4: model = {a, hl[31:0]};
      3'd5: model = {hl[63:32], a};
`ifdef MULDIV_MADD_EN
      3'd6: model = hl + (sa * sb);
      3'd7: model = hl - (sa * sb);
`endif
      default: model = hl;
    endcase
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (Reset === 1'b0 && Done === 1'b1) begin
      if (expQ.size() == 0) check("unexpected_done", 64'(Done), 64'd0);
      else check("result", {HI, LO}, expQ.pop_front());
    end
  end

  // Called at a negedge with Busy low; leaves inputs idle unless b2b is set
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit b2b);
    int cyc;
    bit isMD;
    isMD = (op <= 3'd3);
`ifdef MULDIV_MADD_EN
    isMD = isMD || (op >= 3'd6);
`endif
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(negedge CLK);
    Start = 1'b0;
    OperandA = $urandom;
    OperandB = $urandom;
    if (!isMD) begin
      check("mt_busy", 64'(Busy), 64'd0);
      check("mt_done", 64'(Done), 64'd0);
      check("mt_hilo", {HI, LO}, exp);
      mHL = exp;
      return;
    end
    expQ.push_back(exp);
    check("busy_rise", 64'(Busy), 64'd1);
    cyc = 1;
    while (Busy === 1'b1 && cyc < 100) begin
      if (cyc == 4) begin
        Start = 1'b1;
        Op = 3'($urandom);
      end
      if (cyc == 7) Start = 1'b0;
      if (cyc == 12) check("hold_hilo", {HI, LO}, mHL);
      @(negedge CLK);
      if (Busy === 1'b1) cyc++;
    end
    Start = 1'b0;
    check("busy_cycles", 64'(cyc), 64'd33);
    check("done_pulse", 64'(Done), 64'd1);
    mHL = exp;
    if (!b2b) begin
      @(negedge CLK);
      check("done_once", 64'(Done), 64'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          dn;
    Reset = 1'b1; Start = 1'b0; Op = 3'd0; OperandA = '0; OperandB = '0;
    mHL = 64'd0;
    repeat (3) @(negedge CLK);
    check("reset_hi", 64'(HI), 64'd0);
    check("reset_lo", 64'(LO), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    Reset = 1'b0;
    @(negedge CLK);

    runOp(3'd4, 32'h12345678, 32'h0, 64'h12345678_00000000, 1'b0);
    runOp(3'd5, 32'h9ABCDEF0, 32'h0, 64'h12345678_9ABCDEF0, 1'b0);
    runOp(3'd0, 32'hFFFFFFFE, 32'h3, 64'hFFFFFFFF_FFFFFFFA, 1'b0);
    runOp(3'd1, 32'hFFFFFFFE, 32'h3, 64'h00000002_FFFFFFFA, 1'b0);
    runOp(3'd2, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    runOp(3'd3, 32'h7, 32'h0, 64'h00000007_FFFFFFFF, 1'b0);
    runOp(3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    runOp(3'd2, 32'hFFFFFF00, 32'h0, 64'hFFFFFF00_FFFFFFFF, 1'b0);
`ifdef MULDIV_MADD_EN
    runOp(3'd4, 32'h0, 32'h0, {32'h0, mHL[31:0]}, 1'b0);
    runOp(3'd5, 32'd10, 32'h0, 64'd10, 1'b0);
    runOp(3'd6, 32'd3, 32'd4, 64'd22, 1'b0);
    runOp(3'd7, 32'd5, 32'd5, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
`else
    runOp(3'd6, 32'hDEADBEEF, 32'h5, mHL, 1'b0);
    runOp(3'd7, 32'hCAFEF00D, 32'h9, mHL, 1'b0);
`endif

    // Start held in the Done cycle must launch the next operation
    runOp(3'd1, 32'hABCD1234, 32'h00FF00FF, model(3'd1, 32'hABCD1234, 32'h00FF00FF, mHL), 1'b1);
    runOp(3'd2, 32'h87654321, 32'h00001234, model(3'd2, 32'h87654321, 32'h00001234, mHL), 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
        3: b = $urandom_range(1, 300);
        default: ;
      endcase
      runOp(op, a, b, model(op, a, b, mHL), 1'b0);
    end

    // Abort a multiply with reset ten cycles in
    Start = 1'b1; Op = 3'd0; OperandA = 32'h00012345; OperandB = 32'h00006789;
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_hilo", {HI, LO}, 64'd0);
    mHL = 64'd0;
    dn = 0;
    repeat (40) begin
      @(negedge CLK);
      if (Done === 1'b1) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);

    check("scoreboard_empty", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
